// File: rtl/tag_alloc_hub.sv
// Tag allocator: free-bitmap pool with multi-channel zero-latency issue and retire.
// Grants are priority-ordered by channel; double retires are flagged sticky.
module tag_alloc_hub #(
  parameter int tag_w    = 6,
  parameter int channels = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [channels-1:0]       issue_req,
  output logic [channels-1:0]       issue_gnt,
  output logic [channels*tag_w-1:0] issue_tag,
  input  logic [channels-1:0]       retire_valid,
  input  logic [channels*tag_w-1:0] retire_tag,
  input  logic                      flush,
  output logic [tag_w:0]            free_count,
  output logic                      empty,
  output logic                      err_dbl,
  output logic [tag_w-1:0]          err_tag
);

  localparam int unsigned    ntags      = 2**tag_w;
  localparam logic [tag_w:0] full_count = (tag_w+1)'(ntags);
  localparam logic [tag_w:0] one        = (tag_w+1)'(1);

  logic [ntags-1:0] free_q;
  logic [ntags-1:0] avail;
  logic [ntags-1:0] free_nxt;
  logic [ntags-1:0] seen;
  logic             found;
  logic [tag_w:0]   gnt_cnt;
  logic [tag_w:0]   ret_cnt;
  logic             dbl_any;
  logic [tag_w-1:0] dbl_tag;
  logic [tag_w-1:0] rt;

  // Each channel takes the lowest tag still available after lower channels picked.
  always_comb begin
    issue_gnt = '0;
    issue_tag = '0;
    avail     = free_q;
    gnt_cnt   = '0;
    found     = 1'b0;
    for (int unsigned c = 0; c < channels; c++) begin
      found = 1'b0;
      if (rst && !flush && issue_req[c]) begin
        for (int unsigned t = 0; t < ntags; t++) begin
          if (!found && avail[t]) begin
            found                      = 1'b1;
            issue_gnt[c]               = 1'b1;
            issue_tag[c*tag_w +: tag_w] = t[tag_w-1:0];
            avail[t]                   = 1'b0;
            gnt_cnt                    = gnt_cnt + one;
          end
        end
      end
    end
  end

  // A retire counts as double if the tag was free at the edge or already
  // returned by a lower channel this cycle; only the first such is captured.
  always_comb begin
    free_nxt = avail;
    seen     = '0;
    ret_cnt  = '0;
    dbl_any  = 1'b0;
    dbl_tag  = '0;
    rt       = '0;
    for (int unsigned c = 0; c < channels; c++) begin
      rt = retire_tag[c*tag_w +: tag_w];
      if (retire_valid[c]) begin
        if (free_q[rt] || seen[rt]) begin
          if (!dbl_any) begin
            dbl_any = 1'b1;
            dbl_tag = rt;
          end
        end else begin
          seen[rt]     = 1'b1;
          free_nxt[rt] = 1'b1;
          ret_cnt      = ret_cnt + one;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      free_q     <= '1;
      free_count <= full_count;
      err_dbl    <= 1'b0;
      err_tag    <= '0;
    end else if (flush) begin
      free_q     <= '1;
      free_count <= full_count;
    end else begin
      free_q     <= free_nxt;
      free_count <= free_count + ret_cnt - gnt_cnt;
      if (dbl_any) begin
        err_dbl <= 1'b1;
        if (!err_dbl) err_tag <= dbl_tag;
      end
    end
  end

  assign empty = (free_count == '0);

endmodule

// File: tb/tb_tag_alloc_hub.sv
// Bench for tag_alloc_hub (tag_w=3, channels=2) against an array-based pool model.
module tb_tag_alloc_hub;

  logic       clk;
  logic       rst;
  logic [1:0] issue_req;
  logic [1:0] issue_gnt;
  logic [5:0] issue_tag;
  logic [1:0] retire_valid;
  logic [5:0] retire_tag;
  logic       flush;
  logic [3:0] free_count;
  logic       empty;
  logic       err_dbl;
  logic [2:0] err_tag;

  int errors = 0;
  int checks = 0;

  tag_alloc_hub #(.tag_w(3), .channels(2)) dut (
    .clk(clk), .rst(rst),
    .issue_req(issue_req), .issue_gnt(issue_gnt), .issue_tag(issue_tag),
    .retire_valid(retire_valid), .retire_tag(retire_tag), .flush(flush),
    .free_count(free_count), .empty(empty), .err_dbl(err_dbl), .err_tag(err_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pool model: one flag per tag, errors as first-seen record.
  bit         m_free[8];
  bit         m_err;
  logic [2:0] m_etag;
  logic [1:0] exp_gnt;
  logic [5:0] exp_tag;

  function automatic int m_count();
    int n = 0;
    foreach (m_free[i]) n += int'(m_free[i]);
    return n;
  endfunction

  task automatic m_reset();
    foreach (m_free[i]) m_free[i] = 1'b1;
    m_err  = 1'b0;
    m_etag = '0;
  endtask

  task automatic model_eval();
    bit av[8];
    av      = m_free;
    exp_gnt = '0;
    exp_tag = '0;
    for (int ch = 0; ch < 2; ch++) begin
      if (issue_req[ch] && !flush) begin
        for (int t = 0; t < 8; t++) begin
          if (av[t]) begin
            exp_gnt[ch]         = 1'b1;
            exp_tag[ch*3 +: 3]  = 3'(t);
            av[t]               = 1'b0;
            break;
          end
        end
      end
    end
  endtask

  task automatic model_commit();
    bit         old[8];
    bit         back[8];
    logic [2:0] t;
    if (flush) begin
      foreach (m_free[i]) m_free[i] = 1'b1;
      return;
    end
    old = m_free;
    foreach (back[i]) back[i] = 1'b0;
    for (int ch = 0; ch < 2; ch++)
      if (exp_gnt[ch]) m_free[exp_tag[ch*3 +: 3]] = 1'b0;
    for (int ch = 0; ch < 2; ch++) begin
      t = retire_tag[ch*3 +: 3];
      if (retire_valid[ch]) begin
        if (old[t] || back[t]) begin
          if (!m_err) begin
            m_err  = 1'b1;
            m_etag = t;
          end
        end else begin
          back[t]   = 1'b1;
          m_free[t] = 1'b1;
        end
      end
    end
  endtask

  task automatic apply(input logic [1:0] rq, input logic [1:0] rv,
                       input logic [2:0] t0, input logic [2:0] t1, input logic fl);
    @(negedge clk);
    issue_req    = rq;
    retire_valid = rv;
    retire_tag   = {t1, t0};
    flush        = fl;
    #1;
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle();
    issue_req    = '0;
    retire_valid = '0;
    retire_tag   = '0;
    flush        = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    issue_req = 2'b11;
    m_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (issue_gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b want=00", issue_gnt); end
    checks++; if (free_count !== 4'd8) begin errors++; $display("FAIL reset_count got=%0d want=8", free_count); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL reset_empty got=%b want=0", empty); end
    checks++; if ({err_dbl, err_tag} !== 4'b0) begin errors++; $display("FAIL reset_err got=%b/%0d want=0/0", err_dbl, err_tag); end
    issue_req = '0;
  endtask

  task automatic test_fill();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      apply(2'b11, 2'b00, 3'd0, 3'd0, 1'b0);
      checks++; if (issue_gnt !== exp_gnt) begin errors++; $display("FAIL fill_gnt[%0d] got=%b want=%b", i, issue_gnt, exp_gnt); end
      checks++; if (issue_tag !== exp_tag) begin errors++; $display("FAIL fill_tag[%0d] got=%h want=%h", i, issue_tag, exp_tag); end
      advance();
      checks++; if (free_count !== 4'(m_count())) begin errors++; $display("FAIL fill_count[%0d] got=%0d want=%0d", i, free_count, m_count()); end
    end
    checks++; if (empty !== 1'b1 || free_count !== 4'd0) begin errors++; $display("FAIL fill_empty got=%b/%0d want=1/0", empty, free_count); end
  endtask

  task automatic test_last_tag();
    apply(2'b00, 2'b01, 3'd5, 3'd0, 1'b0);
    advance();
    apply(2'b11, 2'b00, 3'd0, 3'd0, 1'b0);
    checks++; if (issue_gnt !== 2'b01 || issue_tag !== 6'o05) begin errors++; $display("FAIL last_tag got=%b/%o want=01/05", issue_gnt, issue_tag); end
    advance();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL last_empty got=%b want=1", empty); end
  endtask

  task automatic test_no_bypass();
    apply(2'b01, 2'b10, 3'd0, 3'd3, 1'b0);
    checks++; if (issue_gnt !== 2'b00) begin errors++; $display("FAIL bypass_gnt got=%b want=00", issue_gnt); end
    advance();
    apply(2'b01, 2'b00, 3'd0, 3'd0, 1'b0);
    checks++; if (issue_gnt !== 2'b01 || issue_tag !== 6'o03) begin errors++; $display("FAIL bypass_next got=%b/%o want=01/03", issue_gnt, issue_tag); end
    advance();
  endtask

  task automatic test_double();
    apply(2'b00, 2'b11, 3'd2, 3'd2, 1'b0);
    advance();
    checks++; if (free_count !== 4'd1) begin errors++; $display("FAIL dbl_count got=%0d want=1", free_count); end
    checks++; if (err_dbl !== 1'b1 || err_tag !== 3'd2) begin errors++; $display("FAIL dbl_err got=%b/%0d want=1/2", err_dbl, err_tag); end
    apply(2'b00, 2'b11, 3'd6, 3'd6, 1'b0);
    advance();
    checks++; if (err_tag !== 3'd2 || free_count !== 4'd2) begin errors++; $display("FAIL dbl_sticky got=%0d/%0d want=2/2", err_tag, free_count); end
  endtask

  task automatic test_flush();
    apply(2'b00, 2'b00, 3'd0, 3'd0, 1'b1);
    advance();
    apply(2'b11, 2'b00, 3'd0, 3'd0, 1'b0); advance();
    apply(2'b11, 2'b00, 3'd0, 3'd0, 1'b0); advance();
    apply(2'b01, 2'b00, 3'd0, 3'd0, 1'b0); advance();
    checks++; if (free_count !== 4'd3) begin errors++; $display("FAIL flush_pre got=%0d want=3", free_count); end
    apply(2'b11, 2'b00, 3'd0, 3'd0, 1'b1);
    checks++; if (issue_gnt !== 2'b00 || issue_tag !== 6'o00) begin errors++; $display("FAIL flush_gnt got=%b/%o want=00/00", issue_gnt, issue_tag); end
    advance();
    checks++; if (free_count !== 4'd8) begin errors++; $display("FAIL flush_count got=%0d want=8", free_count); end
    checks++; if (err_dbl !== 1'b1 || err_tag !== 3'd2) begin errors++; $display("FAIL flush_err got=%b/%0d want=1/2", err_dbl, err_tag); end
  endtask

  task automatic test_random();
    logic [1:0] rq, rv;
    logic [2:0] t[2];
    logic       fl;
    for (int i = 0; i < 400; i++) begin
      rq = 2'($urandom_range(0, 3));
      for (int ch = 0; ch < 2; ch++) begin
        t[ch]  = 3'($urandom_range(0, 7));
        rv[ch] = ($urandom_range(0, 7) == 0) ? 1'b1 : (!m_free[t[ch]] && ($urandom_range(0, 1) == 1));
      end
      fl = ($urandom_range(0, 29) == 0);
      apply(rq, rv, t[0], t[1], fl);
      checks++; if (issue_gnt !== exp_gnt || issue_tag !== exp_tag) begin errors++; $display("FAIL rand_issue[%0d] got=%b/%o want=%b/%o", i, issue_gnt, issue_tag, exp_gnt, exp_tag); end
      advance();
      checks++; if (free_count !== 4'(m_count()) || empty !== (m_count() == 0)) begin errors++; $display("FAIL rand_count[%0d] got=%0d/%b want=%0d", i, free_count, empty, m_count()); end
      checks++; if (err_dbl !== m_err || err_tag !== m_etag) begin errors++; $display("FAIL rand_err[%0d] got=%b/%0d want=%b/%0d", i, err_dbl, err_tag, m_err, m_etag); end
    end
    idle();
  endtask

  task automatic test_reset_midop();
    apply(2'b00, 2'b00, 3'd0, 3'd0, 1'b1); advance();
    apply(2'b11, 2'b00, 3'd0, 3'd0, 1'b0); advance();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++; if (free_count !== 4'd8 || issue_gnt !== 2'b00) begin errors++; $display("FAIL midrst got=%0d/%b want=8/00", free_count, issue_gnt); end
    m_reset();
    issue_req = '0;
    @(negedge clk);
    rst       = 1'b1;
    issue_req = 2'b01;
    #1;
    model_eval();
    checks++; if (issue_gnt !== 2'b01 || issue_tag !== 6'o00) begin errors++; $display("FAIL midrst_first got=%b/%o want=01/00", issue_gnt, issue_tag); end
    advance();
    checks++; if (free_count !== 4'd7 || err_dbl !== 1'b0) begin errors++; $display("FAIL midrst_after got=%0d/%b want=7/0", free_count, err_dbl); end
    idle();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_last_tag();
    test_no_bypass();
    test_double();
    test_flush();
    test_random();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
